// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Frame controller for the UART receive path. Runs at 8x the baud rate,
//   detects a start bit on rx_in, steps the oversample phase (edge_cnt) that
//   feeds the majority-vote sampler, and acts on the sampler's voted bit at
//   each bit boundary (edge_cnt == 7). Deserialises the data word LSB first,
//   checks optional parity and the stop bit, and presents the word with a
//   one-cycle valid strobe plus sticky error flags.
//
// Ports
//   clk          in   receive clock, 8x baud
//   rst          in   asynchronous active-low reset
//   rx_in        in   serial line, idle high (used only for start detection)
//   par_en       in   frame carries a parity bit (latched at frame start)
//   par_typ      in   0 = even, 1 = odd parity (latched at frame start)
//   sampled_bit  in   voted bit from sampler, valid when edge_cnt == 7
//   edge_cnt     out  oversample phase to sampler
//   dat_samp_en  out  sampler enable; low clears sampler history
//   p_data       out  last good received word
//   data_valid   out  one-cycle strobe: p_data updated
//   par_err      out  parity mismatch on last frame
//   stp_err      out  stop bit sampled low on last frame
//   busy         out  frame in progress
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  output logic [2:0]            edge_cnt,
  output logic                  dat_samp_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                  state;
  logic [3:0]              bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    boundary;

  assign boundary = (edge_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      dat_samp_en <= 1'b0;
      p_data      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // edge_cnt stays at 0 in IDLE, so the first boundary after start
      // detection falls exactly 8 clocks later; the 7->0 wrap on the STOP
      // boundary leaves it at 0 for the return to IDLE.
      if (state == IDLE) edge_cnt <= '0;
      else               edge_cnt <= edge_cnt + 3'd1;

      case (state)
        IDLE: begin
          if (!rx_in) begin
            state       <= START;
            par_en_q    <= par_en;
            par_typ_q   <= par_typ;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            dat_samp_en <= 1'b1;
          end
        end

        START: begin
          if (boundary) begin
            if (sampled_bit) begin
              // false start: line went back high before mid-bit
              state       <= IDLE;
              busy        <= 1'b0;
              dat_samp_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (boundary) begin
            shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state <= par_en_q ? PARITY : STOP;
          end
        end

        PARITY: begin
          if (boundary) begin
            par_err <= sampled_bit ^ (^shift_q) ^ par_typ_q;
            state   <= STOP;
          end
        end

        STOP: begin
          if (boundary) begin
            stp_err <= ~sampled_bit;
            if (sampled_bit && !par_err) begin
              p_data     <= shift_q;
              data_valid <= 1'b1;
            end
            state       <= IDLE;
            busy        <= 1'b0;
            dat_samp_en <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
